// File: rtl/fifo_param_if.sv
// ============================================================================
// Module      : fifo_param_if
// Description : Handshake/data bundle between a FIFO user and fifo_param.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface fifo_param_if #(
  parameter int BUS_SIZE   = 5,
  parameter int ADDR_WIDTH = 3
);
  logic                  push;
  logic                  pop;
  logic [BUS_SIZE-1:0]   data_in;
  logic [ADDR_WIDTH-1:0] af_thr;
  logic [ADDR_WIDTH-1:0] ae_thr;
  logic [BUS_SIZE-1:0]   data_out;
  logic                  valid_out;
  logic [ADDR_WIDTH:0]   fill_count;
  logic                  full;
  logic                  empty;
  logic                  almost_full;
  logic                  almost_empty;
  logic                  error;

  modport master (
    output push, pop, data_in, af_thr, ae_thr,
    input  data_out, valid_out, fill_count, full, empty,
           almost_full, almost_empty, error
  );

  modport slave (
    input  push, pop, data_in, af_thr, ae_thr,
    output data_out, valid_out, fill_count, full, empty,
           almost_full, almost_empty, error
  );
endinterface

`default_nettype wire

// File: rtl/fifo_param.sv
// ============================================================================
// Module      : fifo_param
// Description : Parametrised synchronous FIFO with occupancy count, threshold
//               flags and sticky overflow/underflow error.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fifo_param #(
  parameter int BUS_SIZE   = 5,
  parameter int ADDR_WIDTH = 3
) (
  input  wire logic       clk,
  input  wire logic       reset_L,
  fifo_param_if.slave     bus
);

  localparam int                  MEM_LENGTH = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] c_DEPTH    = (ADDR_WIDTH + 1)'(MEM_LENGTH);

  logic [BUS_SIZE-1:0]   r_mem [MEM_LENGTH];
  logic [ADDR_WIDTH-1:0] r_wr_ptr;
  logic [ADDR_WIDTH-1:0] r_rd_ptr;
  logic [ADDR_WIDTH:0]   r_count;
  logic [BUS_SIZE-1:0]   r_data_out;
  logic                  r_valid;
  logic                  r_error;

  logic                  w_full;
  logic                  w_empty;
  logic                  w_pop_ok;
  logic                  w_push_ok;

  assign w_full    = (r_count == c_DEPTH);
  assign w_empty   = (r_count == '0);
  assign w_pop_ok  = bus.pop && !w_empty;
  // A full FIFO can still take a write when the same edge frees a slot.
  assign w_push_ok = bus.push && (!w_full || w_pop_ok);

  // Storage is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (w_push_ok) begin
      r_mem[r_wr_ptr] <= bus.data_in;
    end
  end

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_data_out <= '0;
      r_valid    <= 1'b0;
      r_error    <= 1'b0;
    end else begin
      r_valid <= w_pop_ok;
      if (w_push_ok) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop_ok) begin
        r_rd_ptr   <= r_rd_ptr + 1'b1;
        r_data_out <= r_mem[r_rd_ptr];
      end
      if (w_push_ok && !w_pop_ok) begin
        r_count <= r_count + 1'b1;
      end else if (w_pop_ok && !w_push_ok) begin
        r_count <= r_count - 1'b1;
      end
      if ((bus.push && !w_push_ok) || (bus.pop && !w_pop_ok)) begin
        r_error <= 1'b1;
      end
    end
  end

  assign bus.data_out     = r_data_out;
  assign bus.valid_out    = r_valid;
  assign bus.fill_count   = r_count;
  assign bus.full         = w_full;
  assign bus.empty        = w_empty;
  assign bus.almost_full  = (c_DEPTH - r_count) <= {1'b0, bus.af_thr};
  assign bus.almost_empty = r_count <= {1'b0, bus.ae_thr};
  assign bus.error        = r_error;

endmodule

`default_nettype wire

// File: doc/fifo_param.md
Name: fifo_param

Overview:
Parametrised synchronous FIFO built around a dual-pointer memory. It is the successor of the team's plain dual-port memory. It adds on-chip pointer management, an occupancy count, full/empty flags, programmable almost-full/almost-empty thresholds and a sticky overflow/underflow error. It sits between link-layer producers and consumers as the standard per-lane/per-class buffer.

Parameters:
BUS_SIZE, 5, data word width in bits
ADDR_WIDTH, 3, pointer width; depth = 2^ADDR_WIDTH
MEM_LENGTH, 1 << ADDR_WIDTH, derived depth (8 by default); not to be overridden independently

Ports:
clk  input  1  rising-edge clock
reset_L  input  1  asynchronous, active-low reset
push  input  1  write request; data_in captured when accepted
pop  input  1  read request
data_in  input  BUS_SIZE  write data
af_thr  input  ADDR_WIDTH  almost-full threshold (free slots)
ae_thr  input  ADDR_WIDTH  almost-empty threshold (occupied words)
data_out  output  BUS_SIZE  registered read data
valid_out  output  1  one-cycle strobe: data_out updated this cycle
fill_count  output  ADDR_WIDTH+1  current occupancy, 0..MEM_LENGTH
full  output  1  fill_count == MEM_LENGTH
empty  output  1  fill_count == 0
almost_full  output  1  (MEM_LENGTH - fill_count) <= af_thr
almost_empty  output  1  fill_count <= ae_thr
error  output  1  sticky overflow/underflow indicator

Behaviour:
- Reset (reset_L low, asynchronous): wr_ptr=0, rd_ptr=0, fill_count=0, data_out=0, valid_out=0, error=0.
  - Resulting flags: empty=1, full=0, almost_empty=1, almost_full=1 only if af_thr >= MEM_LENGTH (never at defaults).
  - Memory array is not cleared.
  - Reset takes effect immediately mid-operation; stored data is discarded.
- Pointers:
  - ADDR_WIDTH bits, wrap naturally modulo MEM_LENGTH.
  - wr_ptr increments on accepted push; rd_ptr increments on accepted pop.
- Push acceptance: push && (!full || pop_accepted). On acceptance, mem[wr_ptr] <= data_in at the edge.
- Pop acceptance: pop && !empty.
  - On acceptance, data_out <= mem[rd_ptr] and valid_out <= 1 at the same edge (1-cycle latency from request).
  - No bypass: a word pushed in cycle N is poppable from cycle N+1.
- valid_out: 0 in every cycle without an accepted pop. data_out holds its last value when no pop is accepted.
- fill_count update:
  - +1 for an accepted push only.
  - -1 for an accepted pop only.
  - Unchanged when both or neither are accepted.
- Simultaneous push & pop:
  - Full: both accepted, count stays MEM_LENGTH.
  - Empty: push accepted, pop rejected (underflow), count becomes 1.
  - Otherwise: both accepted.
- Errors (error <= 1, held until reset):
  - Overflow: push while full with no accepted pop; the write is dropped, memory and pointers are untouched.
  - Underflow: pop while empty; no read, valid_out stays 0, data_out unchanged.
- Flags:
  - Combinational decode of the registered fill_count and the live threshold inputs.
  - Threshold changes affect almost_* in the same cycle.
  - Subtraction is done at ADDR_WIDTH+1 bits, with no underflow since fill_count <= MEM_LENGTH.
- Request inputs are assumed synchronous to clk; no internal synchronisers.

Test Plan:
1. Reset with push=pop=0 -> fill_count=0, empty=1, full=0, almost_empty=1, valid_out=0, data_out=0, error=0.
2. af_thr=2, ae_thr=1; push 8 words 0x01..0x08 -> after 1st push almost_empty=1; after 2nd almost_empty=0; after 6th almost_full=1; after 8th full=1, fill_count=8, error=0.
3. From full, push 0x1F without pop -> error=1, fill_count=8; then pop 8 times -> data_out 0x01..0x08 in order, each one cycle after its pop with valid_out=1, empty=1 at end.
4. From full, push 0x15 and pop together for 3 cycles -> fill_count stays 8, outputs 0x01,0x02,0x03; subsequent drain returns 0x04..0x08 then 0x15,0x15,0x15 (pointer wrap verified).
5. Empty FIFO, pop alone -> valid_out=0, data_out unchanged, error=1; next cycle push 0x0A with pop -> fill_count=1, valid_out=0; next pop -> data_out=0x0A.
6. Push 5 words, assert reset_L low between edges -> fill_count=0, empty=1, error=0, valid_out=0 immediately without waiting for clk; after release, first pushed word is the first popped.
